// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a little-endian word memory.
// Sub-word stores are read-modify-write. Bad requests are answered with err_o and never touch memory.
module load_store_unit #(
   parameter int unsigned MEM_BYTES = 128
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        sign_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   input  logic [31:0] mem_data_i
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state_q, state_d;
   logic        we_q;
   logic [1:0]  size_q;
   logic        sign_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [31:0] rdata_q;
   logic [31:0] wword_q;

   logic [2:0]  nbytes;
   logic [32:0] end_addr;
   logic        req_err;
   logic [31:0] load_val;
   logic [31:0] merged;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // 33-bit end address so a wrapping addr_i cannot slip under the limit
   always_comb begin
      nbytes   = 3'd4;
      if (size_i == 2'b00) nbytes = 3'd1;
      else if (size_i == 2'b01) nbytes = 3'd2;
      end_addr = {1'b0, addr_i} + {30'b0, nbytes};
      req_err  = (size_i == 2'b11)
               | ((size_i == 2'b01) & addr_i[0])
               | ((size_i == 2'b10) & (addr_i[1:0] != 2'b00))
               | (end_addr > 33'(MEM_BYTES));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_i) begin
               if (req_err)                        state_d = RESP;
               else if (!we_i)                     state_d = RD;
               else if (size_i == 2'b10)           state_d = WR;
               else                                state_d = RD;
            end
         end
         RD:      state_d = we_q ? WR : RESP;
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      lane_b   = mem_data_i[{addr_q[1:0], 3'b000} +: 8];
      lane_h   = mem_data_i[{addr_q[1], 4'b0000} +: 16];
      load_val = mem_data_i;
      if (size_q == 2'b00)
         load_val = sign_q ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
      else if (size_q == 2'b01)
         load_val = sign_q ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
      merged = mem_data_i;
      if (size_q == 2'b00)
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= '0;
         sign_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         wword_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (req_i) begin
                  we_q    <= we_i;
                  size_q  <= size_i;
                  sign_q  <= sign_i;
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  err_q   <= req_err;
                  if (we_i && (size_i == 2'b10) && !req_err) wword_q <= wdata_i;
               end
            end
            RD: begin
               if (we_q) wword_q <= merged;
               else      rdata_q <= load_val;
            end
            default: ;
         endcase
      end
   end

   assign ready_o     = (state_q == IDLE);
   assign done_o      = (state_q == RESP);
   assign err_o       = (state_q == RESP) & err_q;
   assign rdata_o     = rdata_q;
   assign mem_addr_o  = {addr_q[31:2], 2'b00};
   assign mem_data_o  = wword_q;
   assign mem_read_o  = (state_q == RD);
   assign mem_write_o = (state_q == WR);

endmodule
